// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common data bus arbiter.
// Source indices identify which functional unit produced a broadcast.
package cdb_arbiter_pkg;

  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;
  localparam int CDB_SRC_MUL = 2;

  localparam int CDB_NUM_SRC_DEF = 3;
  localparam int CDB_TAG_W_DEF   = 4;
  localparam int CDB_DEPTH_DEF   = 2;

  // Round-robin search position: k steps past the last winner, modulo n.
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/cdb_skid_fifo.sv
// Per-producer result queue. Every state change is gated by rdy and flush
// empties the queue. Full is detected by count, so pointers wrap freely.
module cdb_skid_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_DEPTH_DEF,
  parameter int W     = CDB_TAG_W_DEF + 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (rst && rdy && !flush && push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast among NUM_SRC
// producers, each fronted by a small queue with an empty-queue bypass.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC_DEF,
  parameter int TAG_W   = CDB_TAG_W_DEF,
  parameter int DEPTH   = CDB_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        rollback,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*32-1:0]       src_result,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  output logic                        bus_valid,
  output logic [31:0]                 bus_result,
  output logic [TAG_W-1:0]            bus_tag,
  output logic [$clog2(NUM_SRC)-1:0]  bus_src
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int W     = TAG_W + 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic [NUM_SRC-1:0] push_ok, cand, fifo_push, fifo_pop, empty, full;
  logic [W-1:0]       din       [NUM_SRC];
  logic [W-1:0]       head      [NUM_SRC];
  logic [W-1:0]       cand_data [NUM_SRC];
  logic [CW-1:0]      count     [NUM_SRC];
  logic [SRC_W-1:0]   last, winner;
  logic               found, grant;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign din[i]       = {src_tag[i*TAG_W +: TAG_W], src_result[i*32 +: 32]};
    assign src_ready[i] = ~full[i];
    assign push_ok[i]   = rdy & ~rollback & src_valid[i] & src_ready[i];
    assign cand[i]      = (count[i] != '0) | push_ok[i];
    assign cand_data[i] = empty[i] ? din[i] : head[i];
    // A bypass winner goes straight to the bus and is never enqueued.
    assign fifo_pop[i]  = grant & (winner == SRC_W'(i)) & ~empty[i];
    assign fifo_push[i] = push_ok[i] & ~(grant & (winner == SRC_W'(i)) & empty[i]);

    cdb_skid_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .flush (rollback),
      .din   (din[i]),
      .head  (head[i]),
      .count (count[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin : p_search
    logic [SRC_W-1:0] idx;
    found  = 1'b0;
    winner = last;
    idx    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = SRC_W'(rr_next(int'(last), k, NUM_SRC));
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant = found & rdy & ~rollback;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_valid  <= 1'b0;
      bus_result <= '0;
      bus_tag    <= '0;
      bus_src    <= '0;
      last       <= SRC_W'(NUM_SRC - 1);
    end else if (rdy) begin
      if (grant) begin
        bus_valid             <= 1'b1;
        {bus_tag, bus_result} <= cand_data[winner];
        bus_src               <= winner;
        last                  <= winner;
      end else begin
        bus_valid <= 1'b0;
      end
    end
  end

endmodule
